// File: rtl/uart_transmitter.sv
`default_nettype none
// =============================================================================
// Module   : uart_transmitter
// Brief    : UART serialiser with a one-entry holding register, optional
//            parity, 1/2 stop bits and line-break generation.
// Revision : 1.0
// =============================================================================
module uart_transmitter #(
    parameter int CLOCK_DIVISOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     dataIn,
    input  logic                           sendReq,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    input  logic                           sendBreak,
    output logic                           tx,
    output logic                           txReady,
    output logic                           busy,
    output logic                           frameDone
);

    localparam int                 c_cnt_w   = CLOCK_DIVISOR_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one = {{CLOCK_DIVISOR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_DATA   = 4'd2,
        S_PARITY = 4'd3,
        S_STOP1  = 4'd4,
        S_STOP2  = 4'd5,
        S_BREAK  = 4'd6,
        S_MARK   = 4'd7
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     hold_q, hold_d;
    logic                           hold_full_q, hold_full_d;
    logic [7:0]                     shift_q, shift_d;
    logic [1:0]                     dbits_q, dbits_d;
    logic                           has_par_q, has_par_d;
    logic [1:0]                     par_mode_q, par_mode_d;
    logic                           two_stop_q, two_stop_d;
    logic [CLOCK_DIVISOR_WIDTH-1:0] div_q, div_d;
    logic [c_cnt_w-1:0]             cnt_q, cnt_d;
    logic [2:0]                     bit_idx_q, bit_idx_d;
    logic                           par_acc_q, par_acc_d;
    logic [3:0]                     brk_cnt_q, brk_cnt_d;
    logic                           tx_q, tx_d;

    logic       w_bit_end;
    logic       w_last_data;
    logic [3:0] w_frame_bits;
    logic       w_brk_long;
    logic       w_frame_end;
    logic       w_start_frame;
    logic       w_start_break;

    // A bit period spans 2*(div+1) cycles, so its last count is 2*div+1.
    assign w_bit_end    = (cnt_q == {div_q, 1'b1});
    assign w_last_data  = (bit_idx_q == ({1'b0, dbits_q} + 3'd4));
    assign w_frame_bits = 4'd7 + {2'b00, dbits_q} + {3'b000, has_par_q} + {3'b000, two_stop_q};
    assign w_brk_long   = ((brk_cnt_q + 4'd1) >= w_frame_bits);

    assign tx      = tx_q;
    assign txReady = ~hold_full_q;
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        shift_d       = shift_q;
        dbits_d       = dbits_q;
        has_par_d     = has_par_q;
        par_mode_d    = par_mode_q;
        two_stop_d    = two_stop_q;
        div_d         = div_q;
        bit_idx_d     = bit_idx_q;
        par_acc_d     = par_acc_q;
        brk_cnt_d     = brk_cnt_q;
        cnt_d         = ((state_q == S_IDLE) || w_bit_end) ? '0 : cnt_q + c_cnt_one;
        tx_d          = 1'b1;
        frameDone     = 1'b0;
        w_frame_end   = 1'b0;
        w_start_frame = 1'b0;
        w_start_break = 1'b0;

        // Accept and frame-load are mutually exclusive: one needs holding empty, the other full.
        if (sendReq && !hold_full_q) begin
            hold_d      = dataIn;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sendBreak) begin
                    w_start_break = 1'b1;
                end else if (hold_full_q) begin
                    w_start_frame = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    par_acc_d = par_acc_q ^ shift_q[0];
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (w_last_data) begin
                        state_d = has_par_q ? S_PARITY : S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (w_bit_end) begin
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (w_bit_end) begin
                    w_frame_end = 1'b1;
                end
            end
            S_BREAK: begin
                if (w_bit_end) begin
                    if (brk_cnt_q < 4'd14) begin
                        brk_cnt_d = brk_cnt_q + 4'd1;
                    end
                    if (w_brk_long && !sendBreak) begin
                        state_d = S_MARK;
                    end
                end
            end
            S_MARK: begin
                if (w_bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_frame_end) begin
            frameDone = 1'b1;
            if (sendBreak) begin
                w_start_break = 1'b1;
            end else if (hold_full_q) begin
                w_start_frame = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (w_start_break || w_start_frame) begin
            dbits_d    = dataBits;
            has_par_d  = hasParity;
            par_mode_d = parityMode;
            two_stop_d = extraStopBit;
            div_d      = clockDivisor;
        end

        if (w_start_break) begin
            state_d   = S_BREAK;
            brk_cnt_d = 4'd0;
        end

        if (w_start_frame) begin
            state_d     = S_START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            par_acc_d   = 1'b0;
            bit_idx_d   = 3'd0;
        end

        // Line level is registered from the next state so tx never glitches.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: begin
                case (par_mode_q)
                    2'b00:   tx_d = 1'b0;
                    2'b11:   tx_d = 1'b1;
                    2'b10:   tx_d = par_acc_d;
                    default: tx_d = ~par_acc_d;
                endcase
            end
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            dbits_q     <= '0;
            has_par_q   <= 1'b0;
            par_mode_q  <= '0;
            two_stop_q  <= 1'b0;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            par_acc_q   <= 1'b0;
            brk_cnt_q   <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            dbits_q     <= dbits_d;
            has_par_q   <= has_par_d;
            par_mode_q  <= par_mode_d;
            two_stop_q  <= two_stop_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            par_acc_q   <= par_acc_d;
            brk_cnt_q   <= brk_cnt_d;
            tx_q        <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_transmitter
// Brief    : Scoreboard bench: stimulus queues expected frames/breaks, a line
//            monitor decodes tx and compares.
// Revision : 1.0
// =============================================================================
module tb_uart_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic        sendReq = 1'b0;
    logic [1:0]  dataBits = 2'd3;
    logic        hasParity = 1'b0;
    logic [1:0]  parityMode = 2'b00;
    logic        extraStopBit = 1'b0;
    logic [23:0] clockDivisor = 24'd0;
    logic        sendBreak = 1'b0;
    logic        tx, txReady, busy, frameDone;

    uart_transmitter #(.CLOCK_DIVISOR_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .sendReq(sendReq),
        .dataBits(dataBits), .hasParity(hasParity), .parityMode(parityMode),
        .extraStopBit(extraStopBit), .clockDivisor(clockDivisor),
        .sendBreak(sendBreak), .tx(tx), .txReady(txReady), .busy(busy),
        .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_brk;
        logic [7:0]  data;
        logic [1:0]  dbits;
        logic        has_par;
        logic        exp_par;
        logic        two_stop;
        int unsigned div;
        logic        contig;
        int unsigned min_bp;
    } item_t;

    item_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic        mon_en = 1'b0;
    logic        prev_tx = 1'b1;
    int unsigned last_end_cyc = 0;
    int unsigned rel_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic item_t mk_frame(input logic [7:0] d, input logic [1:0] db, input logic hp,
                                       input logic ep, input logic ts, input int unsigned dv,
                                       input logic ct);
        item_t it;
        it.is_brk = 1'b0; it.data = d; it.dbits = db; it.has_par = hp; it.exp_par = ep;
        it.two_stop = ts; it.div = dv; it.contig = ct; it.min_bp = 0;
        return it;
    endfunction

    function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm);
        logic [7:0] m;
        logic x;
        m = 8'hFF >> (3 - int'(db));
        x = ^(d & m);
        case (pm)
            2'b00:   return 1'b0;
            2'b11:   return 1'b1;
            2'b10:   return x;
            default: return ~x;
        endcase
    endfunction

    task automatic mon_frame(input item_t it);
        logic eb [12];
        int   n, nd, bp, fd_cnt, fd_pos, c_idx;
        logic seen;
        bp = 2 * (int'(it.div) + 1);
        nd = int'(it.dbits) + 5;
        eb[0] = 1'b0;
        for (int i = 0; i < nd; i++) eb[1 + i] = it.data[i];
        n = 1 + nd;
        if (it.has_par) begin eb[n] = it.exp_par; n++; end
        eb[n] = 1'b1; n++;
        if (it.two_stop) begin eb[n] = 1'b1; n++; end
        if (it.contig) chk("frame_gap", cyc, last_end_cyc + 1);
        fd_cnt = 0; fd_pos = -1; c_idx = 0;
        for (int b = 0; b < n; b++) begin
            seen = eb[b];
            for (int c = 0; c < bp; c++) begin
                if (c_idx != 0) @(negedge clk);
                if (tx !== eb[b]) seen = tx;
                if (frameDone === 1'b1) begin
                    fd_cnt++;
                    if (fd_pos < 0) fd_pos = c_idx;
                end
                c_idx++;
            end
            chk($sformatf("line_bit%0d_byte%02h", b, it.data), {31'd0, seen}, {31'd0, eb[b]});
        end
        chk("frameDone_count", fd_cnt, 1);
        chk("frameDone_pos", fd_pos, c_idx - 1);
        last_end_cyc = cyc;
    endtask

    task automatic mon_break(input item_t it);
        int bp, low, high;
        bp = 2 * (int'(it.div) + 1);
        low = 0;
        while (tx === 1'b0 && low < 3000) begin
            low++;
            @(negedge clk);
        end
        chk("break_low_whole_bp", low % bp, 0);
        chk("break_low_min", {31'd0, (low >= int'(it.min_bp) * bp)}, 1);
        chk("break_after_release", {31'd0, (cyc > rel_cyc)}, 1);
        chk("break_end_within_bp", {31'd0, (cyc - rel_cyc <= bp)}, 1);
        high = 0;
        while (tx === 1'b1 && busy === 1'b1 && high < 3000) begin
            high++;
            @(negedge clk);
        end
        chk("mark_len", high, bp);
        chk("mark_then_idle_busy", {31'd0, busy}, 0);
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: tx fell with nothing expected (cycle %0d)", cyc);
                end else begin
                    it = exp_q.pop_front();
                    if (it.is_brk) mon_break(it);
                    else           mon_frame(it);
                end
            end
            prev_tx = tx;
        end
    end

    task automatic set_cfg(input logic [1:0] db, input logic hp, input logic [1:0] pm,
                           input logic ts, input int unsigned dv);
        dataBits = db; hasParity = hp; parityMode = pm; extraStopBit = ts;
        clockDivisor = 24'(dv);
    endtask

    task automatic pulse_write(input logic [7:0] b);
        dataIn  = b;
        sendReq = 1'b1;
        @(posedge clk);
        #1;
        sendReq = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (txReady !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk(nm, {31'd0, txReady}, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && txReady === 1'b1 && exp_q.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk(nm, {31'd0, busy}, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        item_t bi;
        logic [7:0]  b;
        int unsigned dv;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, tx}, 1);
        chk("reset_txReady", {31'd0, txReady}, 1);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_frameDone", {31'd0, frameDone}, 0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // 8N1 0x55, divisor 0: latency and line sequence
        set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 0);
        @(negedge clk);
        exp_q.push_back(mk_frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0));
        pulse_write(8'h55);
        chk("lat_txReady_after_N", {31'd0, txReady}, 0);
        chk("lat_tx_after_N", {31'd0, tx}, 1);
        @(posedge clk);
        #1;
        chk("lat_tx_after_N1", {31'd0, tx}, 0);
        chk("lat_txReady_after_N1", {31'd0, txReady}, 1);
        chk("lat_busy_after_N1", {31'd0, busy}, 1);
        wait_idle("idle_8n1");

        // 7E2 0x83, divisor 3: data 1,1,0,0,0,0,0 -> even parity 0
        set_cfg(2'd2, 1'b1, 2'b10, 1'b1, 3);
        @(negedge clk);
        exp_q.push_back(mk_frame(8'h83, 2'd2, 1'b1, 1'b0, 1'b1, 3, 1'b0));
        pulse_write(8'h83);
        wait_idle("idle_7e2");

        // Back-to-back 0xA5, 0x3C; a third write while full is dropped
        set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 0);
        @(negedge clk);
        exp_q.push_back(mk_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0));
        pulse_write(8'hA5);
        @(negedge clk);
        wait_ready("b2b_ready");
        exp_q.push_back(mk_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 0, 1'b1));
        pulse_write(8'h3C);
        @(negedge clk);
        pulse_write(8'hFF);
        chk("b2b_full_txReady", {31'd0, txReady}, 0);
        wait_idle("idle_b2b");
        repeat (10) @(negedge clk);
        chk("b2b_no_third_busy", {31'd0, busy}, 0);

        // Break during 5N1, divisor 1 (BP=4); byte 0x6B waits in holding
        set_cfg(2'd0, 1'b0, 2'b00, 1'b0, 1);
        @(negedge clk);
        bi = mk_frame(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        bi.is_brk = 1'b1;
        bi.min_bp = 7;
        exp_q.push_back(bi);
        exp_q.push_back(mk_frame(8'h6B, 2'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0));
        sendBreak = 1'b1;
        repeat (4) @(negedge clk);
        pulse_write(8'h6B);
        repeat (81) @(negedge clk);
        rel_cyc = cyc;
        sendBreak = 1'b0;
        wait_idle("idle_break");

        // Reset while in DATA aborts the frame and empties holding
        mon_en = 1'b0;
        set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 3);
        @(negedge clk);
        pulse_write(8'hF0);
        repeat (14) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 1);
        pulse_write(8'h11);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_tx", {31'd0, tx}, 1);
        chk("midrst_txReady", {31'd0, txReady}, 1);
        chk("midrst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        exp_q.push_back(mk_frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 3, 1'b0));
        pulse_write(8'h96);
        wait_idle("idle_after_reset");

        // All parity modes x data widths x stop counts; config scrambled mid-frame
        for (int pm = 0; pm < 4; pm++) begin
            for (int db = 0; db < 4; db++) begin
                for (int ts = 0; ts < 2; ts++) begin
                    dv = $urandom_range(0, 3);
                    b  = 8'($urandom);
                    set_cfg(2'(db), 1'b1, 2'(pm), 1'(ts), dv);
                    @(negedge clk);
                    exp_q.push_back(mk_frame(b, 2'(db), 1'b1, ref_parity(b, 2'(db), 2'(pm)),
                                             1'(ts), dv, 1'b0));
                    pulse_write(b);
                    repeat (3) @(negedge clk);
                    set_cfg(~2'(db), 1'b0, ~2'(pm), ~1'(ts), dv + 5);
                    wait_idle("idle_loop");
                end
            end
        end

        wait_idle("idle_final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
